// File: rtl/sp_access_ctrl_if.sv
// sp_access_ctrl_if: request, scratchpad and response signals of the scratchpad access sequencer
//   slave  : the sequencer (receives requests, drives the scratchpad strobes and responses)
//   master : the requester / scratchpad side (drives requests and sp_rdata)
//   req_*  : single-request handshake (valid/ready) with op, src, dst, wdata
//   sp_*   : addr/rd/wr/wdata strobes to the decoder, rdata back (combinational)
//   rsp_*  : one-cycle completion pulse with data, H:L pointer and error flag
interface sp_access_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [2:0]  req_src;
    logic [2:0]  req_dst;
    logic [7:0]  req_wdata;
    logic [2:0]  sp_addr;
    logic        sp_rd;
    logic        sp_wr;
    logic [7:0]  sp_wdata;
    logic [7:0]  sp_rdata;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic [13:0] rsp_addr;
    logic        rsp_err;

    modport slave (
        input  req_valid, req_op, req_src, req_dst, req_wdata, sp_rdata,
        output req_ready, sp_addr, sp_rd, sp_wr, sp_wdata,
               rsp_valid, rsp_data, rsp_addr, rsp_err
    );

    modport master (
        output req_valid, req_op, req_src, req_dst, req_wdata, sp_rdata,
        input  req_ready, sp_addr, sp_rd, sp_wr, sp_wdata,
               rsp_valid, rsp_data, rsp_addr, rsp_err
    );
endinterface

// File: rtl/sp_access_ctrl.sv
// sp_access_ctrl: sequences RD/WR/MOV/HL requests into scratchpad addr/rd/wr strobes
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : sp_access_ctrl_if.slave (request handshake, scratchpad strobes, response)
//   Optional feature macro SP_CTRL_HL_EN enables the H:L pointer fetch (req_op=3);
//   without it op 3 is rejected and rsp_addr is tied to 0.
module sp_access_ctrl (
    input  logic            clk,
    input  logic            rst_n,
    sp_access_ctrl_if.slave bus
);
    localparam logic [1:0] OP_RD  = 2'd0;
    localparam logic [1:0] OP_WR  = 2'd1;
    localparam logic [1:0] OP_MOV = 2'd2;
    localparam logic [1:0] OP_HL  = 2'd3;
    localparam logic [2:0] REG_M  = 3'd7;
`ifdef SP_CTRL_HL_EN
    localparam logic [2:0] REG_H  = 3'd5;
    localparam logic [2:0] REG_L  = 3'd6;
    localparam logic       HL_EN  = 1'b1;
`else
    localparam logic       HL_EN  = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, RD, WR, MOV_RD, MOV_WR, HL_H, HL_L, RESP} state_t;

    state_t      state_q, state_d;
    logic [2:0]  dst_q, dst_d;
    logic [7:0]  temp_q, temp_d;
    logic [2:0]  sp_addr_q, sp_addr_d;
    logic        sp_rd_q, sp_rd_d;
    logic        sp_wr_q, sp_wr_d;
    logic [7:0]  sp_wdata_q, sp_wdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;
`ifdef SP_CTRL_HL_EN
    logic [5:0]  h_q, h_d;
    logic [13:0] rsp_addr_q, rsp_addr_d;
`endif
    logic        uses_src, uses_dst, illegal;

    assign uses_src = (bus.req_op == OP_RD) || (bus.req_op == OP_MOV);
    assign uses_dst = (bus.req_op == OP_WR) || (bus.req_op == OP_MOV);
    assign illegal  = (uses_src && bus.req_src == REG_M) || (uses_dst && bus.req_dst == REG_M) ||
                      (bus.req_op == OP_HL && !HL_EN);

    // Strobes are computed for the state being entered so they come straight from flops.
    always_comb begin
        state_d     = state_q;
        dst_d       = dst_q;
        temp_d      = temp_q;
        sp_addr_d   = 3'd0;
        sp_rd_d     = 1'b0;
        sp_wr_d     = 1'b0;
        sp_wdata_d  = 8'd0;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
`ifdef SP_CTRL_HL_EN
        h_d         = h_q;
        rsp_addr_d  = rsp_addr_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    dst_d = bus.req_dst;
                    if (illegal) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        case (bus.req_op)
                            OP_RD: begin
                                state_d   = RD;
                                sp_rd_d   = 1'b1;
                                sp_addr_d = bus.req_src;
                            end
                            OP_WR: begin
                                state_d    = WR;
                                sp_wr_d    = 1'b1;
                                sp_addr_d  = bus.req_dst;
                                sp_wdata_d = bus.req_wdata;
                            end
                            OP_MOV: begin
                                state_d   = MOV_RD;
                                sp_rd_d   = 1'b1;
                                sp_addr_d = bus.req_src;
                            end
                            default: begin
`ifdef SP_CTRL_HL_EN
                                state_d   = HL_H;
                                sp_rd_d   = 1'b1;
                                sp_addr_d = REG_H;
`endif
                            end
                        endcase
                    end
                end
            end
            RD: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_data_d  = bus.sp_rdata;
            end
            WR: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
            end
            MOV_RD: begin
                // The write is issued from the captured value, so src==dst is harmless.
                state_d    = MOV_WR;
                temp_d     = bus.sp_rdata;
                sp_wr_d    = 1'b1;
                sp_addr_d  = dst_q;
                sp_wdata_d = bus.sp_rdata;
            end
            MOV_WR: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_data_d  = temp_q;
            end
`ifdef SP_CTRL_HL_EN
            HL_H: begin
                state_d   = HL_L;
                h_d       = bus.sp_rdata[5:0];
                sp_rd_d   = 1'b1;
                sp_addr_d = REG_L;
            end
            HL_L: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_addr_d  = {h_q, bus.sp_rdata};
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            dst_q       <= 3'd0;
            temp_q      <= 8'd0;
            sp_addr_q   <= 3'd0;
            sp_rd_q     <= 1'b0;
            sp_wr_q     <= 1'b0;
            sp_wdata_q  <= 8'd0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'd0;
            rsp_err_q   <= 1'b0;
`ifdef SP_CTRL_HL_EN
            h_q         <= 6'd0;
            rsp_addr_q  <= 14'd0;
`endif
        end else begin
            state_q     <= state_d;
            dst_q       <= dst_d;
            temp_q      <= temp_d;
            sp_addr_q   <= sp_addr_d;
            sp_rd_q     <= sp_rd_d;
            sp_wr_q     <= sp_wr_d;
            sp_wdata_q  <= sp_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
`ifdef SP_CTRL_HL_EN
            h_q         <= h_d;
            rsp_addr_q  <= rsp_addr_d;
`endif
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.sp_addr   = sp_addr_q;
    assign bus.sp_rd     = sp_rd_q;
    assign bus.sp_wr     = sp_wr_q;
    assign bus.sp_wdata  = sp_wdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
`ifdef SP_CTRL_HL_EN
    assign bus.rsp_addr  = rsp_addr_q;
`else
    assign bus.rsp_addr  = 14'd0;
`endif
endmodule
